// File: rtl/redmule_pkg.sv
// Shared RedMulE offload definitions: opcode constants, offload classes,
// and the default-geometry offload entry.
package redmule_pkg;

  localparam logic [6:0] MCNFIG      = 7'b0001011;
  localparam logic [6:0] MARITH      = 7'b0101011;
  localparam logic [6:0] ISOLDE      = 7'b1011011;
  localparam logic [6:0] ISOLDE_GEMM = 7'b0000001;

  localparam int unsigned OFFL_INSTR_W = 32;
  localparam int unsigned OFFL_DATA_W  = 32;
  localparam int unsigned OFFL_NUM_RS  = 3;
  localparam int unsigned OFFL_NUM_IMM = 4;
  localparam int unsigned OFFL_ID_W    = 4;

  typedef enum logic [1:0] {
    OFFL_NONE,
    OFFL_CFG,
    OFFL_ARITH,
    OFFL_GEMM
  } offl_class_e;

  typedef struct packed {
    logic [OFFL_INSTR_W-1:0]                   instr;
    logic [OFFL_NUM_RS-1:0][OFFL_DATA_W-1:0]   rs;
    logic [OFFL_NUM_IMM-1:0][OFFL_DATA_W-1:0]  imm;
    logic [OFFL_ID_W-1:0]                      id;
  } offl_entry_t;

  // ARITH and GEMM entries terminate a job; CFG entries only write config.
  function automatic logic offl_is_job(offl_class_e c);
    return (c == OFFL_ARITH) || (c == OFFL_GEMM);
  endfunction

endpackage

// File: rtl/redmule_offload_queue_if.sv
// Issue-side and replay-side handshake bundle of the offload queue.
interface redmule_offload_queue_if #(
  parameter int unsigned InstrWidth = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned NumRs      = 3,
  parameter int unsigned NumImm     = 4,
  parameter int unsigned IdWidth    = 4
);
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic                        in_accept_o;
  logic [InstrWidth-1:0]       in_instr_i;
  logic [NumRs*DataWidth-1:0]  in_rs_i;
  logic                        in_rs_valid_i;
  logic [NumImm*DataWidth-1:0] in_imm_i;
  logic                        in_imm_valid_i;
  logic [IdWidth-1:0]          in_id_i;

  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [InstrWidth-1:0]       out_instr_o;
  logic [NumRs*DataWidth-1:0]  out_rs_o;
  logic [NumImm*DataWidth-1:0] out_imm_o;
  logic [IdWidth-1:0]          out_id_o;

  // Queue side.
  modport slave (
    input  in_valid_i, in_instr_i, in_rs_i, in_rs_valid_i, in_imm_i, in_imm_valid_i, in_id_i,
    output in_ready_o, in_accept_o,
    output out_valid_o, out_instr_o, out_rs_o, out_imm_o, out_id_o,
    input  out_ready_i
  );

  // Core / decoder side.
  modport master (
    output in_valid_i, in_instr_i, in_rs_i, in_rs_valid_i, in_imm_i, in_imm_valid_i, in_id_i,
    input  in_ready_o, in_accept_o,
    input  out_valid_o, out_instr_o, out_rs_o, out_imm_o, out_id_o,
    output out_ready_i
  );
endinterface

// File: rtl/redmule_offload_classify.sv
// Combinational classifier of an issue request into an offload class.
// wait_o flags a RedMulE opcode whose operands are not yet valid.
module redmule_offload_classify
  import redmule_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [6:0]  funct7_i,
  input  logic        rs_valid_i,
  input  logic        imm_valid_i,
  output offl_class_e class_o,
  output logic        wait_o
);

  // Decode opcode/funct7 and operand validity into class and wait flag.
  always_comb begin
    class_o = OFFL_NONE;
    wait_o  = 1'b0;
    if (opcode_i == MCNFIG) begin
      if (rs_valid_i) class_o = OFFL_CFG;
      else            wait_o  = 1'b1;
    end else if (opcode_i == MARITH) begin
      if (rs_valid_i) class_o = OFFL_ARITH;
      else            wait_o  = 1'b1;
    end else if ((opcode_i == ISOLDE) && (funct7_i == ISOLDE_GEMM)) begin
      if (rs_valid_i && imm_valid_i) class_o = OFFL_GEMM;
      else                           wait_o  = 1'b1;
    end
  end

endmodule

// File: rtl/redmule_offload_queue.sv
// Offload queue: accepts classified XIF issue requests into a FIFO and
// replays them one at a time to the decoder over valid/ready.
module redmule_offload_queue
  import redmule_pkg::*;
#(
  parameter int unsigned Depth      = 4,
  parameter int unsigned InstrWidth = OFFL_INSTR_W,
  parameter int unsigned DataWidth  = OFFL_DATA_W,
  parameter int unsigned NumRs      = OFFL_NUM_RS,
  parameter int unsigned NumImm     = OFFL_NUM_IMM,
  parameter int unsigned IdWidth    = OFFL_ID_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  redmule_offload_queue_if.slave       bus,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic [$clog2(Depth+1)-1:0]   jobs_pending_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  typedef struct packed {
    logic                        job;
    logic [IdWidth-1:0]          id;
    logic [NumImm*DataWidth-1:0] imm;
    logic [NumRs*DataWidth-1:0]  rs;
    logic [InstrWidth-1:0]       instr;
  } entry_t;

  entry_t          mem_q [Depth];
  entry_t          head;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d, jobs_q, jobs_d;
  offl_class_e     cls;
  logic            op_wait, full, ready, accept, push, pop;

  redmule_offload_classify i_classify (
    .opcode_i    (bus.in_instr_i[6:0]),
    .funct7_i    (bus.in_instr_i[31:25]),
    .rs_valid_i  (bus.in_rs_valid_i),
    .imm_valid_i (bus.in_imm_valid_i),
    .class_o     (cls),
    .wait_o      (op_wait)
  );

  // Issue response: non-RedMulE requests are always consumed, RedMulE ones
  // only when there is room; a flush cycle consumes nothing.
  always_comb begin
    full   = (count_q == CntW'(Depth));
    ready  = 1'b0;
    accept = 1'b0;
    if (bus.in_valid_i && !clear_i && !op_wait) begin
      if (cls == OFFL_NONE) begin
        ready = 1'b1;
      end else begin
        ready  = !full;
        accept = !full;
      end
    end
    push = accept;
    pop  = (count_q != '0) && bus.out_ready_i;
  end

  // Pointer, occupancy and pending-job bookkeeping.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    jobs_d  = jobs_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      jobs_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(pop);
      jobs_d  = jobs_q + CntW'(push && offl_is_job(cls))
                       - CntW'(pop && mem_q[rptr_q].job);
    end
  end

  // State registers and entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      jobs_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      jobs_q  <= jobs_d;
      if (push) begin
        mem_q[wptr_q] <= '{job:   offl_is_job(cls),
                           id:    bus.in_id_i,
                           imm:   bus.in_imm_i,
                           rs:    bus.in_rs_i,
                           instr: bus.in_instr_i};
      end
    end
  end

  assign head            = mem_q[rptr_q];
  assign bus.in_ready_o  = ready;
  assign bus.in_accept_o = accept;
  assign bus.out_valid_o = (count_q != '0);
  assign bus.out_instr_o = head.instr;
  assign bus.out_rs_o    = head.rs;
  assign bus.out_imm_o   = head.imm;
  assign bus.out_id_o    = head.id;
  assign count_o         = count_q;
  assign jobs_pending_o  = jobs_q;

endmodule
